block_mover: RTL and testbench

//   Sweeps the player's block horizontally along the current row; sits directly

---
 rtl/block_mover.sv | 135 +++++++++++++
 tb/tb_block_mover.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/block_mover.sv
// Horizontal sweeper for the player's block: latches a row on load, steps one
// pixel every diff_q frame ticks, bounces at the screen edges and lands on drop.
module block_mover #(
  parameter logic [7:0] X_MIN = 8'd0,
  parameter logic [7:0] X_MAX = 8'd144
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic       frame_tick,
  input  logic       drop,
  input  logic [2:0] difficulty,
  input  logic       new_direction,
  input  logic [7:0] new_x_position,
  input  logic [6:0] new_y_position,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic       direction,
  output logic       moving,
  output logic       step_pulse,
  output logic       done
);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, LANDED = 2'd2} state_t;

  state_t     state_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic       dir_q;
  logic       moving_q;
  logic       step_q;
  logic       done_q;
  logic [2:0] diff_q;
  logic [2:0] count_q;

  logic [7:0] load_x_d;
  logic [2:0] load_diff_d;
  logic       step_tick_d;
  logic [7:0] step_x_d;
  logic       step_dir_d;

  // Clamped load values and the position/direction a step tick would produce.
  always_comb begin
    if (new_x_position >= X_MAX) begin
      load_x_d = X_MAX;
    end else if (new_x_position <= X_MIN) begin
      load_x_d = X_MIN;
    end else begin
      load_x_d = new_x_position;
    end
    load_diff_d = (difficulty == 3'd0) ? 3'd1 : difficulty;
    step_tick_d = frame_tick && (count_q == (diff_q - 3'd1));
    step_x_d    = x_q;
    step_dir_d  = dir_q;
    if (dir_q) begin
      if (x_q >= X_MAX) begin
        step_dir_d = 1'b0;
        step_x_d   = X_MAX - 8'd1;
      end else begin
        step_x_d   = x_q + 8'd1;
      end
    end else begin
      if (x_q <= X_MIN) begin
        step_dir_d = 1'b1;
        step_x_d   = X_MIN + 8'd1;
      end else begin
        step_x_d   = x_q - 8'd1;
      end
    end
  end

  // Row FSM with registered outputs; load overrides every state, drop beats a step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      dir_q    <= 1'b1;
      moving_q <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= 3'd1;
      count_q  <= 3'd0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      if (load) begin
        state_q  <= MOVE;
        moving_q <= 1'b1;
        x_q      <= load_x_d;
        y_q      <= new_y_position;
        dir_q    <= new_direction;
        diff_q   <= load_diff_d;
        count_q  <= 3'd0;
      end else begin
        case (state_q)
          MOVE: begin
            if (drop) begin
              state_q  <= LANDED;
              moving_q <= 1'b0;
              done_q   <= 1'b1;
            end else if (step_tick_d) begin
              count_q <= 3'd0;
              x_q     <= step_x_d;
              dir_q   <= step_dir_d;
              step_q  <= 1'b1;
            end else if (frame_tick) begin
              count_q <= count_q + 3'd1;
            end else begin
              count_q <= count_q;
            end
          end
          LANDED: begin
            state_q <= IDLE;
          end
          IDLE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q  <= IDLE;
            moving_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign direction  = dir_q;
  assign moving     = moving_q;
  assign step_pulse = step_q;
  assign done       = done_q;

endmodule

// File: tb/tb_block_mover.sv
// Self-checking bench for block_mover: expected step events are queued when
// the stimulus is driven and popped when the DUT raises step_pulse.
module tb_block_mover;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       load = 1'b0;
  logic       frame_tick = 1'b0;
  logic       drop = 1'b0;
  logic [2:0] difficulty = 3'd1;
  logic       new_direction = 1'b1;
  logic [7:0] new_x_position = 8'd0;
  logic [6:0] new_y_position = 7'd0;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic       direction;
  logic       moving;
  logic       step_pulse;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         tick;
    logic [7:0] x;
    logic       dir;
  } step_t;
  step_t sb[$];

  block_mover dut (
    .clk(clk), .resetn(resetn), .load(load), .frame_tick(frame_tick),
    .drop(drop), .difficulty(difficulty), .new_direction(new_direction),
    .new_x_position(new_x_position), .new_y_position(new_y_position),
    .x_pos(x_pos), .y_pos(y_pos), .direction(direction), .moving(moving),
    .step_pulse(step_pulse), .done(done)
  );

  always #5 clk = ~clk;

  // One clock: inputs held across the edge, outputs sampled 1 time unit later.
  task automatic cyc(input logic ld, input logic tk, input logic dp);
    load = ld; frame_tick = tk; drop = dp;
    @(posedge clk); #1;
    load = 1'b0; frame_tick = 1'b0; drop = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] x, input logic [6:0] y,
                         input logic dir, input logic [2:0] diff);
    new_x_position = x; new_y_position = y; new_direction = dir; difficulty = diff;
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    n_cmp++; if (x_pos !== 8'd0) begin n_err++; $display("FAIL reset_x: got %0d want 0", x_pos); end
    n_cmp++; if (y_pos !== 7'd0) begin n_err++; $display("FAIL reset_y: got %0d want 0", y_pos); end
    n_cmp++; if ({direction, moving, step_pulse, done} !== 4'b1000) begin
      n_err++; $display("FAIL reset_flags: got %b want 1000", {direction, moving, step_pulse, done}); end
    resetn = 1'b1;
    do_load(8'd50, 7'd33, 1'b0, 3'd1);
    n_cmp++; if (x_pos !== 8'd50 || moving !== 1'b1) begin
      n_err++; $display("FAIL reset_preload: got x=%0d mv=%b want x=50 mv=1", x_pos, moving); end
    resetn = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    resetn = 1'b1;
    n_cmp++; if (x_pos !== 8'd0 || y_pos !== 7'd0 || {direction, moving, done} !== 3'b100) begin
      n_err++; $display("FAIL reset_midmove: got x=%0d y=%0d d/m/dn=%b want 0 0 100",
                        x_pos, y_pos, {direction, moving, done}); end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    n_cmp++; if (x_pos !== 8'd0 || step_pulse !== 1'b0 || moving !== 1'b0) begin
      n_err++; $display("FAIL reset_nomotion: got x=%0d sp=%b mv=%b want 0 0 0", x_pos, step_pulse, moving); end
  endtask

  task automatic test_step_rate;
    step_t e;
    do_load(8'd0, 7'd104, 1'b1, 3'd3);
    n_cmp++; if (x_pos !== 8'd0 || y_pos !== 7'd104 || moving !== 1'b1 || direction !== 1'b1) begin
      n_err++; $display("FAIL rate_load: got x=%0d y=%0d mv=%b dir=%b want 0 104 1 1",
                        x_pos, y_pos, moving, direction); end
    sb.push_back('{3, 8'd1, 1'b1});
    sb.push_back('{6, 8'd2, 1'b1});
    sb.push_back('{9, 8'd3, 1'b1});
    for (int t = 1; t <= 9; t++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (step_pulse === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rate_extra_step: got step after tick %0d want none", t);
        end else begin
          e = sb.pop_front();
          if (t != e.tick || x_pos !== e.x) begin
            n_err++; $display("FAIL rate_step: got tick=%0d x=%0d want tick=%0d x=%0d", t, x_pos, e.tick, e.x);
          end
        end
      end
      // Difficulty changes mid-row must not affect the latched rate.
      difficulty = 3'd1;
      cyc(1'b0, 1'b0, 1'b0);
      n_cmp++; if (step_pulse !== 1'b0) begin
        n_err++; $display("FAIL rate_pulse_width: got sp=%b want 0 after tick %0d", step_pulse, t); end
    end
    n_cmp++; if (sb.size() != 0) begin
      n_err++; $display("FAIL rate_missing_steps: got %0d left want 0", sb.size()); sb.delete(); end
    n_cmp++; if (x_pos !== 8'd3) begin n_err++; $display("FAIL rate_final_x: got %0d want 3", x_pos); end
  endtask

  task automatic test_edges;
    do_load(8'd144, 7'd10, 1'b1, 3'd1);
    cyc(1'b0, 1'b1, 1'b0);
    n_cmp++; if (x_pos !== 8'd143 || direction !== 1'b0 || step_pulse !== 1'b1) begin
      n_err++; $display("FAIL edge_right: got x=%0d dir=%b sp=%b want 143 0 1", x_pos, direction, step_pulse); end
    do_load(8'd0, 7'd10, 1'b0, 3'd1);
    cyc(1'b0, 1'b1, 1'b0);
    n_cmp++; if (x_pos !== 8'd1 || direction !== 1'b1 || step_pulse !== 1'b1) begin
      n_err++; $display("FAIL edge_left: got x=%0d dir=%b sp=%b want 1 1 1", x_pos, direction, step_pulse); end
  endtask

  task automatic test_back_to_back;
    step_t e;
    do_load(8'd200, 7'd20, 1'b1, 3'd2);
    n_cmp++; if (x_pos !== 8'd144) begin n_err++; $display("FAIL clamp_x: got %0d want 144", x_pos); end
    do_load(8'd10, 7'd20, 1'b1, 3'd0);
    for (int i = 1; i <= 4; i++) begin
      sb.push_back('{i, 8'(10 + i), 1'b1});
      cyc(1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (step_pulse !== 1'b1) begin
        n_err++; $display("FAIL diff0_step: got sp=%b want 1 on tick %0d", step_pulse, i);
        void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        if (x_pos !== e.x || direction !== e.dir) begin
          n_err++; $display("FAIL diff0_x: got x=%0d dir=%b want x=%0d dir=%b", x_pos, direction, e.x, e.dir);
        end
      end
    end
  endtask

  task automatic test_drop_tick;
    do_load(8'd20, 7'd40, 1'b1, 3'd1);
    cyc(1'b0, 1'b1, 1'b1);
    n_cmp++; if (x_pos !== 8'd20 || step_pulse !== 1'b0 || done !== 1'b1 || moving !== 1'b0) begin
      n_err++; $display("FAIL drop_tick: got x=%0d sp=%b dn=%b mv=%b want 20 0 1 0",
                        x_pos, step_pulse, done, moving); end
    cyc(1'b0, 1'b1, 1'b1);
    n_cmp++; if (done !== 1'b0 || x_pos !== 8'd20) begin
      n_err++; $display("FAIL drop_once: got dn=%b x=%0d want 0 20", done, x_pos); end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    n_cmp++; if (x_pos !== 8'd20 || y_pos !== 7'd40 || step_pulse !== 1'b0 || done !== 1'b0 || moving !== 1'b0) begin
      n_err++; $display("FAIL drop_idle: got x=%0d y=%0d sp=%b dn=%b mv=%b want 20 40 0 0 0",
                        x_pos, y_pos, step_pulse, done, moving); end
  endtask

  task automatic test_load_drop;
    do_load(8'd30, 7'd50, 1'b1, 3'd2);
    cyc(1'b0, 1'b1, 1'b0);
    new_x_position = 8'd60; new_y_position = 7'd5; new_direction = 1'b0; difficulty = 3'd2;
    cyc(1'b1, 1'b0, 1'b1);
    n_cmp++; if (done !== 1'b0 || moving !== 1'b1 || x_pos !== 8'd60 || y_pos !== 7'd5 || direction !== 1'b0) begin
      n_err++; $display("FAIL load_drop: got dn=%b mv=%b x=%0d y=%0d dir=%b want 0 1 60 5 0",
                        done, moving, x_pos, y_pos, direction); end
    cyc(1'b0, 1'b1, 1'b0);
    n_cmp++; if (step_pulse !== 1'b0 || x_pos !== 8'd60) begin
      n_err++; $display("FAIL load_drop_count: got sp=%b x=%0d want 0 60", step_pulse, x_pos); end
    cyc(1'b0, 1'b1, 1'b0);
    n_cmp++; if (step_pulse !== 1'b1 || x_pos !== 8'd59) begin
      n_err++; $display("FAIL load_drop_step: got sp=%b x=%0d want 1 59", step_pulse, x_pos); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_step_rate();
    test_edges();
    test_back_to_back();
    test_drop_tick();
    test_load_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
